neuron_layer_sequencer: RTL and testbench
=========================================

Name: neuron_layer_sequencer

Overview:
- Sequences one fully-connected layer through the 784-input pipelined dot-product neuron calculator.
- Streams one neuron's weight vector per cycle from the weight memory into the calculator, keeping the pipeline full.
- Tags every issued neuron through the calculator latency and writes each 16-bit neuron output to the result memory.
- Sits between the layer/top-level control (start/done) and the calculator, weight memory and result memory.

Parameters:
- NUM_NEURONS, 10, neurons per layer; range 1..2^ADDR_W.
- PIPE_LAT, 11, calculator register stages from sampled weights to valid output.
- ADDR_W, 8, width of neuron index / memory addresses.
- DATA_W, 16, result word width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a layer; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until the last result write, inclusive.
- done  out  1  one-cycle pulse after the last result write.
- w_rd_en  out  1  weight memory read enable.
- w_rd_addr  out  ADDR_W  neuron index being read; memory returns data one cycle later, wired straight to the calculator weights.
- calc_en  out  1  calculator run enable; 1 = pipeline advances.
- calc_out  in  DATA_W  calculator output.
- res_wr_en  out  1  result memory write strobe.
- res_addr  out  ADDR_W  result index.
- res_data  out  DATA_W  result value.

Behaviour:
- Reset: all outputs 0; state IDLE; issue counter, tag shift register and write counter cleared. Reset has priority over start and aborts any layer in flight. No writes occur after reset, and done does not pulse.
- FSM states:
  - IDLE: start=1 -> ISSUE (accepted at cycle 0).
  - ISSUE: w_rd_en=1, w_rd_addr=k in cycle k+1, for k=0..NUM_NEURONS-1. After the last address -> DRAIN.
  - DRAIN: w_rd_en=0; waits until the last tag leaves the pipeline.
  - DONE: one cycle, done=1, busy=0 -> IDLE.
- start while not IDLE is ignored and does not queue.
- Timing: an address issued in cycle c has its data sampled by the calculator at the end of cycle c+1. Its output is valid in cycle c+1+PIPE_LAT.
- Tag pipeline: valid bit plus index, depth PIPE_LAT+1, shifted every cycle while busy.
- A tag exiting the pipeline causes, in that cycle: res_wr_en=1, res_addr=index, res_data=calc_out.
- Result order equals issue order; there are no gaps or duplicates.
- calc_en = busy. The calculator never freezes mid-layer.
- Outputs produced while no valid tag is present (stale pipeline contents) are never written.
- Latency: last write in cycle NUM_NEURONS+PIPE_LAT+1. done and busy=0 in the following cycle.
- Back-to-back layers: start is accepted in the cycle after done (IDLE).
- NUM_NEURONS=1: single issue in cycle 1, write in cycle PIPE_LAT+2, done in cycle PIPE_LAT+3.
- NUM_NEURONS=2^ADDR_W: counters must not wrap early. The issue counter is ADDR_W+1 bits wide.
- No arithmetic on data other than the optional clamp; res_data is calc_out unchanged.

Optional Feature:
- Macro: SEQ_RELU_EN.
- Defined: res_data = 0 when calc_out[DATA_W-1]=1 (negative), else calc_out. This is a combinational ReLU on the write path and adds no latency.
- Undefined: res_data = calc_out unchanged, including negative values.

Test Plan:
- Reset then idle 20 cycles -> all outputs 0, no w_rd_en, no res_wr_en, calc_en=0.
- NUM_NEURONS=10, start pulse at cycle 0:
  - w_rd_addr 0..9 in cycles 1..10.
  - res_wr_en in cycles 13..22 with res_addr 0..9 and res_data = calc_out at those cycles.
  - busy high in cycles 1..22; done=1 and busy=0 in cycle 23.
- Calculator model returns index*0x0100 for neuron index -> result memory holds 0x0000,0x0100,...,0x0900. With SEQ_RELU_EN and the model returning 0xFF00 for index 3 -> entry 3 = 0x0000; without the macro -> 0xFF00.
- start held high continuously through a layer -> exactly one layer runs. A second layer starts the cycle after done (IDLE); its first w_rd_addr=0 appears one cycle later.
- reset asserted in cycle 15 of a 10-neuron layer -> from cycle 16: all outputs 0, no further res_wr_en, done never pulses. A later start runs a clean full layer.
- NUM_NEURONS=1 -> single write at cycle 13, done at cycle 14; NUM_NEURONS=256 with ADDR_W=8 -> 256 writes, addresses 0..255, no wrap.

Source files
------------

// File: rtl/neuron_layer_sequencer.sv
// neuron_layer_sequencer
// Runs one fully-connected layer through the pipelined dot-product calculator.
// It issues one weight-memory read per neuron and tags each issued neuron
// through the calculator latency. It writes each calculator result to the
// result memory in issue order.
// Optional macro SEQ_RELU_EN: clamps negative results to zero on the write path.
module neuron_layer_sequencer #(
  parameter int NUM_NEURONS = 10,
  parameter int PIPE_LAT    = 11,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              w_rd_en,
  output logic [ADDR_W-1:0] w_rd_addr,
  output logic              calc_en,
  input  logic [DATA_W-1:0] calc_out,
  output logic              res_wr_en,
  output logic [ADDR_W-1:0] res_addr,
  output logic [DATA_W-1:0] res_data
);

  // Tag depth covers the memory read cycle plus the calculator stages.
  localparam int unsigned DEPTH = PIPE_LAT + 1;
  localparam int unsigned EXIT  = PIPE_LAT;
  // One extra bit so a 2^ADDR_W neuron layer does not wrap before it finishes.
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(NUM_NEURONS - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W:0]   issue_cnt;
  logic [ADDR_W:0]   wr_cnt;
  logic              tag_v   [DEPTH];
  logic [ADDR_W-1:0] tag_idx [DEPTH];
  logic [DATA_W-1:0] wr_value;

  // State register; reset aborts any layer in flight.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: issue every neuron, then drain until the last tag writes.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ISSUE;
      ISSUE:   if (issue_cnt == LAST_IDX) state_nxt = DRAIN;
      DRAIN:   if (tag_v[EXIT] && (wr_cnt == LAST_IDX)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs; the calculator runs for exactly the busy window.
  always_comb begin
    busy      = (state == ISSUE) || (state == DRAIN);
    done      = (state == DONE);
    w_rd_en   = (state == ISSUE);
    w_rd_addr = (state == ISSUE) ? issue_cnt[ADDR_W-1:0] : '0;
    calc_en   = busy;
  end

  // Issue and write counters; both restart whenever the FSM is idle.
  always_ff @(posedge clk) begin
    if (reset || state == IDLE) begin
      issue_cnt <= '0;
      wr_cnt    <= '0;
    end else begin
      if (state == ISSUE) issue_cnt <= issue_cnt + 1'b1;
      if (tag_v[EXIT])    wr_cnt    <= wr_cnt + 1'b1;
    end
  end

  // Tag pipeline tracks which neuron's result leaves the calculator each cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        tag_v[i]   <= 1'b0;
        tag_idx[i] <= '0;
      end
    end else if (busy) begin
      tag_v[0]   <= w_rd_en;
      tag_idx[0] <= w_rd_addr;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        tag_v[i]   <= tag_v[i-1];
        tag_idx[i] <= tag_idx[i-1];
      end
    end
  end

`ifdef SEQ_RELU_EN
  assign wr_value = calc_out[DATA_W-1] ? '0 : calc_out;
`else
  assign wr_value = calc_out;
`endif

  // Write path: only a valid exiting tag writes; stale calculator output is dropped.
  always_comb begin
    res_wr_en = tag_v[EXIT];
    res_addr  = tag_v[EXIT] ? tag_idx[EXIT] : '0;
    res_data  = tag_v[EXIT] ? wr_value : '0;
  end

endmodule

// File: tb/tb_neuron_layer_sequencer.sv
// Self-checking bench for neuron_layer_sequencer.
// Three instances (10, 1 and 256 neurons) share clock and reset. Each drives a
// model of the weight memory and calculator. Expected writes are queued when a
// layer starts and popped as the DUT writes.
module tb_neuron_layer_sequencer;

  localparam int PIPE_LAT = 11;
  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 16;
  localparam int MLAST    = PIPE_LAT;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic              start_a   [3];
  logic              busy_a    [3];
  logic              done_a    [3];
  logic              w_en_a    [3];
  logic [ADDR_W-1:0] w_addr_a  [3];
  logic              calc_en_a [3];
  logic [DATA_W-1:0] calc_out_a[3];
  logic              res_wr_a  [3];
  logic [ADDR_W-1:0] res_addr_a[3];
  logic [DATA_W-1:0] res_data_a[3];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int                cyc;
  } wr_t;
  wr_t sb[$];

  neuron_layer_sequencer #(.NUM_NEURONS(10), .PIPE_LAT(PIPE_LAT), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut_a (
    .clk(clk), .reset(reset), .start(start_a[0]), .busy(busy_a[0]), .done(done_a[0]),
    .w_rd_en(w_en_a[0]), .w_rd_addr(w_addr_a[0]), .calc_en(calc_en_a[0]), .calc_out(calc_out_a[0]),
    .res_wr_en(res_wr_a[0]), .res_addr(res_addr_a[0]), .res_data(res_data_a[0]));

  neuron_layer_sequencer #(.NUM_NEURONS(1), .PIPE_LAT(PIPE_LAT), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut_b (
    .clk(clk), .reset(reset), .start(start_a[1]), .busy(busy_a[1]), .done(done_a[1]),
    .w_rd_en(w_en_a[1]), .w_rd_addr(w_addr_a[1]), .calc_en(calc_en_a[1]), .calc_out(calc_out_a[1]),
    .res_wr_en(res_wr_a[1]), .res_addr(res_addr_a[1]), .res_data(res_data_a[1]));

  neuron_layer_sequencer #(.NUM_NEURONS(256), .PIPE_LAT(PIPE_LAT), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut_c (
    .clk(clk), .reset(reset), .start(start_a[2]), .busy(busy_a[2]), .done(done_a[2]),
    .w_rd_en(w_en_a[2]), .w_rd_addr(w_addr_a[2]), .calc_en(calc_en_a[2]), .calc_out(calc_out_a[2]),
    .res_wr_en(res_wr_a[2]), .res_addr(res_addr_a[2]), .res_data(res_data_a[2]));

  // Calculator result for a neuron; index 3 yields a negative value.
  function automatic logic [DATA_W-1:0] calc_val(input logic [ADDR_W-1:0] idx);
    logic [DATA_W-1:0] v;
    v = {idx, 8'h00};
    if (idx == 8'd3) v = 16'hFF00;
    return v;
  endfunction

  // Value expected in the result memory for a neuron.
  function automatic logic [DATA_W-1:0] exp_res(input logic [ADDR_W-1:0] idx);
    logic [DATA_W-1:0] v;
    v = calc_val(idx);
`ifdef SEQ_RELU_EN
    if (v[DATA_W-1]) v = '0;
`endif
    return v;
  endfunction

  // Memory read register (stage 0) plus calculator stages 1..PIPE_LAT.
  logic              m_v [3][PIPE_LAT+1];
  logic [ADDR_W-1:0] m_a [3][PIPE_LAT+1];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        for (int j = 0; j <= PIPE_LAT; j++) begin
          m_v[i][j] <= 1'b0;
          m_a[i][j] <= '0;
        end
      end else begin
        m_v[i][0] <= w_en_a[i];
        m_a[i][0] <= w_addr_a[i];
        if (calc_en_a[i]) begin
          for (int j = 1; j <= PIPE_LAT; j++) begin
            m_v[i][j] <= m_v[i][j-1];
            m_a[i][j] <= m_a[i][j-1];
          end
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++)
      calc_out_a[i] = m_v[i][MLAST] ? calc_val(m_a[i][MLAST]) : 16'hA5A5;
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_quiet(input int sel, input string tag);
    checks++;
    if (busy_a[sel] !== 1'b0 || done_a[sel] !== 1'b0 || w_en_a[sel] !== 1'b0 ||
        calc_en_a[sel] !== 1'b0 || res_wr_a[sel] !== 1'b0 || w_addr_a[sel] !== '0 ||
        res_addr_a[sel] !== '0 || res_data_a[sel] !== '0) begin
      failures++;
      $display("FAIL %s inst=%0d cyc=%0d busy=%b done=%b w_en=%b w_addr=%0d calc_en=%b wr=%b res_addr=%0d res_data=%h expected all zero",
               tag, sel, cyc, busy_a[sel], done_a[sel], w_en_a[sel], w_addr_a[sel],
               calc_en_a[sel], res_wr_a[sel], res_addr_a[sel], res_data_a[sel]);
    end
  endtask

  // Runs one layer from cycle 0; with hold, start stays high throughout and on return.
  task automatic run_layer(input int sel, input int n, input bit hold);
    wr_t e;
    logic exp_busy, exp_done, exp_w;
    logic [ADDR_W-1:0] exp_addr;
    sb.delete();
    for (int k = 0; k < n; k++) begin
      e.addr = ADDR_W'(k);
      e.data = exp_res(ADDR_W'(k));
      e.cyc  = k + PIPE_LAT + 2;
      sb.push_back(e);
    end
    start_a[sel] = 1'b1;
    cyc = 0;
    for (int c = 1; c <= n + PIPE_LAT + 3; c++) begin
      step();
      if (!hold) start_a[sel] = 1'b0;
      exp_busy = (c <= n + PIPE_LAT + 1);
      exp_done = (c == n + PIPE_LAT + 2);
      exp_w    = (c <= n);
      exp_addr = exp_w ? ADDR_W'(c - 1) : '0;
      checks++;
      if (busy_a[sel] !== exp_busy || calc_en_a[sel] !== exp_busy) begin
        failures++;
        $display("FAIL busy inst=%0d cyc=%0d busy=%b calc_en=%b expected %b", sel, c, busy_a[sel], calc_en_a[sel], exp_busy);
      end
      checks++;
      if (done_a[sel] !== exp_done) begin
        failures++;
        $display("FAIL done inst=%0d cyc=%0d got=%b expected=%b", sel, c, done_a[sel], exp_done);
      end
      checks++;
      if (w_en_a[sel] !== exp_w || w_addr_a[sel] !== exp_addr) begin
        failures++;
        $display("FAIL issue inst=%0d cyc=%0d w_en=%b addr=%0d expected w_en=%b addr=%0d",
                 sel, c, w_en_a[sel], w_addr_a[sel], exp_w, exp_addr);
      end
      if (res_wr_a[sel] === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL extra_write inst=%0d cyc=%0d addr=%0d data=%h expected no write", sel, c, res_addr_a[sel], res_data_a[sel]);
        end else begin
          e = sb.pop_front();
          if (res_addr_a[sel] !== e.addr || res_data_a[sel] !== e.data || c != e.cyc) begin
            failures++;
            $display("FAIL write inst=%0d cyc=%0d addr=%0d data=%h expected cyc=%0d addr=%0d data=%h",
                     sel, c, res_addr_a[sel], res_data_a[sel], e.cyc, e.addr, e.data);
          end
        end
      end else if (sb.size() > 0 && sb[0].cyc == c) begin
        checks++;
        failures++;
        e = sb.pop_front();
        $display("FAIL missing_write inst=%0d cyc=%0d wr=%b expected addr=%0d", sel, c, res_wr_a[sel], e.addr);
      end
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL write_count inst=%0d outstanding=%0d expected 0", sel, sb.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      for (int s = 0; s < 3; s++) check_quiet(s, "reset_idle");
    end
  endtask

  task automatic test_layer10();
    run_layer(0, 10, 1'b0);
  endtask

  // start held high through a whole layer: one layer, then a second from the IDLE cycle.
  task automatic test_back_to_back();
    run_layer(0, 10, 1'b1);
    run_layer(0, 10, 1'b0);
  endtask

  task automatic test_reset_abort();
    int nwr;
    nwr = 0;
    start_a[0] = 1'b1;
    cyc = 0;
    for (int c = 1; c <= 15; c++) begin
      step();
      start_a[0] = 1'b0;
      if (res_wr_a[0] === 1'b1) begin
        checks++;
        if (res_addr_a[0] !== ADDR_W'(nwr)) begin
          failures++;
          $display("FAIL abort_write cyc=%0d addr=%0d expected %0d", c, res_addr_a[0], nwr);
        end
        nwr++;
      end
    end
    reset = 1'b1;
    checks++;
    if (nwr != 3) begin
      failures++;
      $display("FAIL abort_pre_writes got=%0d expected 3", nwr);
    end
    for (int c = 16; c <= 40; c++) begin
      step();
      reset = 1'b0;
      check_quiet(0, "abort_quiet");
    end
    run_layer(0, 10, 1'b0);
  endtask

  task automatic test_single();
    run_layer(1, 1, 1'b0);
  endtask

  task automatic test_full_range();
    run_layer(2, 256, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) start_a[i] = 1'b0;
    test_reset();
    test_layer10();
    test_back_to_back();
    test_reset_abort();
    test_single();
    test_full_range();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
